// File: rtl/viterbi_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its controller / codec test path.
// Handshake: start_i is a single-cycle request that is accepted only while busy_o is low;
// there is no back-pressure, so a request seen while busy_o is high is dropped, and
// done_o is a one-cycle completion strobe with bit_ct_o/err_ct_o valid from that cycle on.
interface viterbi_frame_sequencer_if;
    logic        start_i;
    logic [15:0] seed_i;
    logic        decoder_o_i;
    logic        encoder_bit_o;
    logic        encoder_en_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] bit_ct_o;
    logic [15:0] err_ct_o;
    logic [2:0]  state_dbg_o;

    // Sequencer side
    modport slave (
        input  start_i, seed_i, decoder_o_i,
        output encoder_bit_o, encoder_en_o, busy_o, done_o, bit_ct_o, err_ct_o, state_dbg_o
    );

    // Controller / test-path side
    modport master (
        output start_i, seed_i, decoder_o_i,
        input  encoder_bit_o, encoder_en_o, busy_o, done_o, bit_ct_o, err_ct_o, state_dbg_o
    );
endinterface

// File: rtl/viterbi_frame_sequencer.sv
// Frame sequencer for the encoder / channel / Viterbi decoder test path: sends an LFSR
// payload plus zero tail, waits out decoder latency and counts decoded bit errors.
module viterbi_frame_sequencer #(
    parameter int FRAME_LEN = 256,
    parameter int TAIL_LEN  = 8,
    parameter int DEC_LAT   = 40
) (
    input  logic                        clk,
    input  logic                        rst,
    viterbi_frame_sequencer_if.slave    bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEND  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [15:0] SEND_LAST  = 16'(FRAME_LEN - 1);
    localparam logic [15:0] FLUSH_LAST = 16'((TAIL_LEN > 0) ? (TAIL_LEN - 1) : 0);
    localparam logic [15:0] DRAIN_LAST = 16'(DEC_LAT - 1);
    localparam logic [15:0] LFSR_INIT  = 16'hACE1;

    logic [2:0]         state_q, state_d;
    logic [15:0]        phase_q, phase_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [DEC_LAT-1:0] dl_flag_q, dl_flag_d;
    logic [DEC_LAT-1:0] dl_bit_q, dl_bit_d;
    logic [15:0]        bit_ct_q, bit_ct_d;
    logic [15:0]        err_ct_q, err_ct_d;

    logic start_acc;
    logic send_act;
    logic lfsr_fb;
    logic cmp_en;
    logic cmp_miss;

    assign start_acc = (state_q == S_IDLE) && bus.start_i;
    assign send_act  = (state_q == S_SEND);
    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
    assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    // The tail stage of the reference line lines up with the decoder output
    assign cmp_en    = dl_flag_q[DEC_LAT-1];
    assign cmp_miss  = bus.decoder_o_i ^ dl_bit_q[DEC_LAT-1];

    // Next-state, phase counter and LFSR stepping
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        lfsr_d  = lfsr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    lfsr_d  = (bus.seed_i == 16'h0000) ? LFSR_INIT : bus.seed_i;
                    phase_d = 16'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                if (phase_q == SEND_LAST) begin
                    phase_d = 16'd0;
                    state_d = (TAIL_LEN == 0) ? S_DRAIN : S_FLUSH;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            S_FLUSH: begin
                if (phase_q == FLUSH_LAST) begin
                    phase_d = 16'd0;
                    state_d = S_DRAIN;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            S_DRAIN: begin
                if (phase_q == DRAIN_LAST) begin
                    phase_d = 16'd0;
                    state_d = S_DONE;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                phase_d = 16'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Reference delay line: payload flag and bit enter at stage 0 every cycle
    always_comb begin
        dl_flag_d    = dl_flag_q << 1;
        dl_bit_d     = dl_bit_q << 1;
        dl_flag_d[0] = send_act;
        dl_bit_d[0]  = send_act & lfsr_q[0];
    end

    // Bit and error counters: cleared on accepted start, error count saturates
    always_comb begin
        bit_ct_d = bit_ct_q;
        err_ct_d = err_ct_q;
        if (start_acc) begin
            bit_ct_d = 16'd0;
            err_ct_d = 16'd0;
        end else if (cmp_en) begin
            bit_ct_d = bit_ct_q + 16'd1;
            if (cmp_miss && (err_ct_q != 16'hFFFF)) begin
                err_ct_d = err_ct_q + 16'd1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            phase_q   <= 16'd0;
            lfsr_q    <= LFSR_INIT;
            dl_flag_q <= '0;
            dl_bit_q  <= '0;
            bit_ct_q  <= 16'd0;
            err_ct_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            lfsr_q    <= lfsr_d;
            dl_flag_q <= dl_flag_d;
            dl_bit_q  <= dl_bit_d;
            bit_ct_q  <= bit_ct_d;
            err_ct_q  <= err_ct_d;
        end
    end

    assign bus.encoder_en_o  = (state_q == S_SEND) || (state_q == S_FLUSH);
    assign bus.encoder_bit_o = send_act & lfsr_q[0];
    assign bus.busy_o        = (state_q != S_IDLE);
    assign bus.done_o        = (state_q == S_DONE);
    assign bus.bit_ct_o      = bit_ct_q;
    assign bus.err_ct_o      = err_ct_q;
    assign bus.state_dbg_o   = state_q;

endmodule

// File: tb/tb_viterbi_frame_sequencer.sv
// Bench for viterbi_frame_sequencer: two instances (default geometry and a minimal
// FRAME_LEN=4 / TAIL_LEN=0 / DEC_LAT=1 one), a channel model per instance, and a
// scoreboard that matches every done_o against the frame expected when it was started.
module tb_viterbi_frame_sequencer;

    localparam int F0 = 256;
    localparam int T0 = 8;
    localparam int D0 = 40;
    localparam int F1 = 4;
    localparam int T1 = 0;
    localparam int D1 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    viterbi_frame_sequencer_if bus0();
    viterbi_frame_sequencer_if bus1();

    viterbi_frame_sequencer #(.FRAME_LEN(F0), .TAIL_LEN(T0), .DEC_LAT(D0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    viterbi_frame_sequencer #(.FRAME_LEN(F1), .TAIL_LEN(T1), .DEC_LAT(D1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // ---------------- shared bench state ----------------
    int checks = 0;
    int errors = 0;
    int start_cyc[2] = '{0, 0};
    int en_cnt[2]    = '{0, 0};
    int mode0 = 0;                       // 0 clean, 1 clean + flips, 2 decoder tied 1
    logic [D0:0] hist0 = '0;
    logic        hist1 = 1'b0;
    // {inst, done_rel_cycle, bit_ct, err_ct, encoder_en cycles}
    logic [64:0] exp_q[$];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    function automatic int lfsr_zeros(input logic [15:0] seed, input int n);
        logic [15:0] l;
        logic        fb;
        int          z;
        z = 0;
        l = (seed == 16'h0000) ? 16'hACE1 : seed;
        for (int i = 0; i < n; i++) begin
            if (!l[0]) z++;
            fb = l[0] ^ l[2] ^ l[3] ^ l[5];
            l  = {fb, l[15:1]};
        end
        return z;
    endfunction

    // ---------------- channel models ----------------
    always @(negedge clk) begin : chan0
        int  rel;
        logic flip;
        rel   = cyc - start_cyc[0] + 1;
        hist0 = {hist0[D0-1:0], bus0.encoder_bit_o & bus0.encoder_en_o};
        if (bus0.encoder_en_o) en_cnt[0]++;
        // 41/150/296 are the first, a middle and the last payload compare; 297/304 are tail-aligned
        flip  = (rel == 41) || (rel == 150) || (rel == 296) || (rel == 297) || (rel == 304);
        case (mode0)
            1:       bus0.decoder_o_i = hist0[D0] ^ flip;
            2:       bus0.decoder_o_i = 1'b1;
            default: bus0.decoder_o_i = hist0[D0];
        endcase
    end

    always @(negedge clk) begin : chan1
        bus1.decoder_o_i = hist1;
        hist1 = bus1.encoder_bit_o & bus1.encoder_en_o;
        if (bus1.encoder_en_o) en_cnt[1]++;
    end

    // ---------------- scoreboard monitor ----------------
    task automatic mon_check(input int inst, input int b, input int e);
        logic [64:0] x;
        int          rel;
        rel = cyc - start_cyc[inst] + 1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected inst%0d: got done at rel %0d bit_ct=%0d err_ct=%0d, required no done",
                     inst, rel, b, e);
            return;
        end
        x = exp_q.pop_front();
        chk($sformatf("done_inst%0d", inst), inst, int'(x[64]));
        chk($sformatf("done_cycle_inst%0d", inst), rel, int'(x[63:48]));
        chk($sformatf("bit_ct_inst%0d", inst), b, int'(x[47:32]));
        chk($sformatf("err_ct_inst%0d", inst), e, int'(x[31:16]));
        chk($sformatf("enc_en_cycles_inst%0d", inst), en_cnt[inst], int'(x[15:0]));
    endtask

    always @(negedge clk) begin : monitor
        if (bus0.done_o === 1'b1) mon_check(0, int'(bus0.bit_ct_o), int'(bus0.err_ct_o));
        if (bus1.done_o === 1'b1) mon_check(1, int'(bus1.bit_ct_o), int'(bus1.err_ct_o));
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; start is sampled at the following rising edge.
    task automatic start_frame(input int inst, input logic [15:0] seed, input int e_bit,
                               input int e_err, input int e_rel, input int e_en);
        exp_q.push_back({inst == 1, 16'(e_rel), 16'(e_bit), 16'(e_err), 16'(e_en)});
        en_cnt[inst] = 0;
        if (inst == 0) begin
            bus0.seed_i  = seed;
            bus0.start_i = 1'b1;
        end else begin
            bus1.seed_i  = seed;
            bus1.start_i = 1'b1;
        end
        @(negedge clk);
        bus0.start_i   = 1'b0;
        bus1.start_i   = 1'b0;
        start_cyc[inst] = cyc;
    endtask

    task automatic pulse0();
        bus0.seed_i  = 16'hFFFF;
        bus0.start_i = 1'b1;
        @(negedge clk);
        bus0.start_i = 1'b0;
    endtask

    task automatic wait_rel(input int inst, input int target);
        for (int i = 0; i < 2000; i++) begin
            if (cyc - start_cyc[inst] + 1 == target) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_rel_timeout inst%0d: got no cycle %0d, required reach within 2000 cycles", inst, target);
    endtask

    task automatic wait_done(input int inst);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ((inst == 0) ? (bus0.done_o === 1'b1) : (bus1.done_o === 1'b1)) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_done_timeout inst%0d: got no done_o, required done within 2000 cycles", inst);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus0.start_i = 1'b0;
        bus0.seed_i  = 16'h0000;
        bus1.start_i = 1'b0;
        bus1.seed_i  = 16'h0000;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_enc_en", bus0.encoder_en_o, 0);
        chk("rst_enc_bit", bus0.encoder_bit_o, 0);
        chk("rst_busy", bus0.busy_o, 0);
        chk("rst_done", bus0.done_o, 0);
        chk("rst_bit_ct", bus0.bit_ct_o, 0);
        chk("rst_err_ct", bus0.err_ct_o, 0);
        chk("rst_busy_inst1", bus1.busy_o, 0);
        rst = 1'b1;
        @(negedge clk);

        // Clean frame with ignored starts in SEND, DRAIN and DONE
        mode0 = 0;
        start_frame(0, 16'h1234, F0, 0, F0 + T0 + D0 + 1, F0 + T0);
        wait_rel(0, 10);
        pulse0();
        wait_rel(0, 280);
        chk("busy_in_drain", bus0.busy_o, 1);
        pulse0();
        wait_rel(0, F0 + T0 + D0 + 1);
        chk("done_high_at_305", bus0.done_o, 1);
        bus0.seed_i  = 16'hFFFF;
        bus0.start_i = 1'b1;
        @(negedge clk);
        chk("idle_after_done_busy", bus0.busy_o, 0);
        chk("hold_bit_ct_after_done_pulse", bus0.bit_ct_o, F0);
        chk("hold_err_ct_after_done_pulse", bus0.err_ct_o, 0);

        // Back-to-back frame in the first IDLE cycle, 3 payload flips + 2 tail flips
        mode0 = 1;
        start_frame(0, 16'h1234, F0, 3, F0 + T0 + D0 + 1, F0 + T0);
        wait_done(0);

        // Decoder tied to 1: error count equals zeros in the payload
        @(negedge clk);
        mode0 = 2;
        start_frame(0, 16'h0000, F0, lfsr_zeros(16'h0000, F0), F0 + T0 + D0 + 1, F0 + T0);
        wait_done(0);
        @(negedge clk);
        start_frame(0, 16'h1234, F0, lfsr_zeros(16'h1234, F0), F0 + T0 + D0 + 1, F0 + T0);
        wait_done(0);

        // Counters hold in IDLE
        repeat (5) @(negedge clk);
        chk("idle_hold_bit_ct", bus0.bit_ct_o, F0);
        chk("idle_hold_err_ct", bus0.err_ct_o, lfsr_zeros(16'h1234, F0));
        chk("idle_hold_done", bus0.done_o, 0);

        // Reset in cycle 100 of SEND
        mode0 = 0;
        start_frame(0, 16'h5555, F0, 0, F0 + T0 + D0 + 1, F0 + T0);
        wait_rel(0, 100);
        chk("send_enc_en_before_rst", bus0.encoder_en_o, 1);
        chk("send_busy_before_rst", bus0.busy_o, 1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_enc_en", bus0.encoder_en_o, 0);
        chk("midrst_enc_bit", bus0.encoder_bit_o, 0);
        chk("midrst_busy", bus0.busy_o, 0);
        chk("midrst_done", bus0.done_o, 0);
        chk("midrst_bit_ct", bus0.bit_ct_o, 0);
        chk("midrst_err_ct", bus0.err_ct_o, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_frame(0, 16'h1234, F0, 0, F0 + T0 + D0 + 1, F0 + T0);
        wait_done(0);

        // Minimal geometry: no tail, one-cycle decoder latency
        @(negedge clk);
        start_frame(1, 16'h1234, F1, 0, F1 + T1 + D1 + 1, F1 + T1);
        wait_done(1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
